// File: rtl/traffic_light_ctrl_if.sv
// traffic_light_ctrl_if: car sensors in, light states / animation strobe / phase out.
// Preemption signals exist only when EMERGENCY_PREEMPT_EN is defined.
interface traffic_light_ctrl_if;
    logic       wait_ns;
    logic       wait_ew;
    logic       animateClk;
    logic       traffic0_color;
    logic       traffic1_color;
    logic       traffic2_color;
    logic       traffic3_color;
    logic [1:0] phase;
`ifdef EMERGENCY_PREEMPT_EN
    logic       preempt;
    logic       preempt_dir;

    modport master (
        input  wait_ns, wait_ew, preempt, preempt_dir,
        output animateClk, traffic0_color, traffic1_color,
               traffic2_color, traffic3_color, phase
    );
    modport slave (
        output wait_ns, wait_ew, preempt, preempt_dir,
        input  animateClk, traffic0_color, traffic1_color,
               traffic2_color, traffic3_color, phase
    );
`else
    modport master (
        input  wait_ns, wait_ew,
        output animateClk, traffic0_color, traffic1_color,
               traffic2_color, traffic3_color, phase
    );
    modport slave (
        output wait_ns, wait_ew,
        input  animateClk, traffic0_color, traffic1_color,
               traffic2_color, traffic3_color, phase
    );
`endif
endinterface

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: four-phase intersection FSM on a prescaled tick, with demand-driven
// early green end. Define EMERGENCY_PREEMPT_EN to add emergency-vehicle preemption.
module traffic_light_ctrl #(
    parameter int unsigned TICK_DIV      = 250000,
    parameter int unsigned ALL_RED_TICKS = 100,
    parameter int unsigned MIN_GREEN     = 300,
    parameter int unsigned MAX_GREEN     = 1000
) (
    input  logic                dclk,
    input  logic                clr,
    traffic_light_ctrl_if.master bus
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(TICK_DIV / 2 - 1);
    localparam logic [15:0]   AR_LAST  = 16'(ALL_RED_TICKS - 1);
    localparam logic [15:0]   MIN_LAST = 16'(MIN_GREEN - 1);
    localparam logic [15:0]   MAX_LAST = 16'(MAX_GREEN - 1);

    typedef enum logic [1:0] {
        ALL_RED_NS = 2'd0,
        NS_GREEN   = 2'd1,
        ALL_RED_EW = 2'd2,
        EW_GREEN   = 2'd3
    } state_t;

    logic [PW-1:0] pre;
    logic          tick;
    logic          anim;
    logic [1:0]    ns_sync;
    logic [1:0]    ew_sync;
    logic          wait_ns_s;
    logic          wait_ew_s;
    state_t        state;
    logic [15:0]   timer;
    logic [3:0]    lights;   // {traffic3, traffic2, traffic1, traffic0}

    assign tick = (pre == PRE_LAST);

    always_ff @(posedge dclk or negedge clr) begin
        if (!clr) begin
            pre  <= '0;
            anim <= 1'b0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick)
                anim <= 1'b1;
            else if (pre == PRE_HALF)
                anim <= 1'b0;
        end
    end

    always_ff @(posedge dclk or negedge clr) begin
        if (!clr) begin
            ns_sync <= '0;
            ew_sync <= '0;
        end else begin
            ns_sync <= {ns_sync[0], bus.wait_ns};
            ew_sync <= {ew_sync[0], bus.wait_ew};
        end
    end

    assign wait_ns_s = ns_sync[1];
    assign wait_ew_s = ew_sync[1];

`ifdef EMERGENCY_PREEMPT_EN
    logic [1:0] pr_sync;
    logic [1:0] pd_sync;
    logic       preempt_s;
    logic       preempt_dir_s;

    always_ff @(posedge dclk or negedge clr) begin
        if (!clr) begin
            pr_sync <= '0;
            pd_sync <= '0;
        end else begin
            pr_sync <= {pr_sync[0], bus.preempt};
            pd_sync <= {pd_sync[0], bus.preempt_dir};
        end
    end

    assign preempt_s     = pr_sync[1];
    assign preempt_dir_s = pd_sync[1];
`endif

    function automatic logic [3:0] lights_of(input state_t s);
        case (s)
            NS_GREEN: return 4'b0101;
            EW_GREEN: return 4'b1010;
            default:  return 4'b0000;
        endcase
    endfunction

    // Lights are decoded from the state being entered so they move on the same edge.
    always_ff @(posedge dclk or negedge clr) begin
        if (!clr) begin
            state  <= ALL_RED_NS;
            timer  <= '0;
            lights <= '0;
        end else if (tick) begin
            case (state)
                ALL_RED_NS: begin
                    if (timer == AR_LAST) begin
                        state  <= NS_GREEN;
                        timer  <= '0;
                        lights <= lights_of(NS_GREEN);
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                NS_GREEN: begin
`ifdef EMERGENCY_PREEMPT_EN
                    if (preempt_s && preempt_dir_s) begin
                        state  <= ALL_RED_EW;
                        timer  <= '0;
                        lights <= lights_of(ALL_RED_EW);
                    end else if (preempt_s) begin
                        timer <= timer;
                    end else
`endif
                    if (timer == MAX_LAST ||
                        (timer >= MIN_LAST && wait_ew_s && !wait_ns_s)) begin
                        state  <= ALL_RED_EW;
                        timer  <= '0;
                        lights <= lights_of(ALL_RED_EW);
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                ALL_RED_EW: begin
                    if (timer == AR_LAST) begin
                        state  <= EW_GREEN;
                        timer  <= '0;
                        lights <= lights_of(EW_GREEN);
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: begin
`ifdef EMERGENCY_PREEMPT_EN
                    if (preempt_s && !preempt_dir_s) begin
                        state  <= ALL_RED_NS;
                        timer  <= '0;
                        lights <= lights_of(ALL_RED_NS);
                    end else if (preempt_s) begin
                        timer <= timer;
                    end else
`endif
                    if (timer == MAX_LAST ||
                        (timer >= MIN_LAST && wait_ns_s && !wait_ew_s)) begin
                        state  <= ALL_RED_NS;
                        timer  <= '0;
                        lights <= lights_of(ALL_RED_NS);
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
            endcase
        end
    end

    assign bus.animateClk     = anim;
    assign bus.traffic0_color = lights[0];
    assign bus.traffic1_color = lights[1];
    assign bus.traffic2_color = lights[2];
    assign bus.traffic3_color = lights[3];
    assign bus.phase          = state;

endmodule
